// File: rtl/gate_share_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// gate_arb_pkg
// Shared definitions for the gate-share arbiter: the FSM state encoding,
// the default requester count and the helper that sizes requester indices.
// No ports; imported by the interface, the picker and the top.
// ----------------------------------------------------------------------------
package gate_arb_pkg;

    localparam int N_REQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Requester-index width. N_REQ is a power of two, so log2 is exact;
    // the floor of 1 keeps the index a legal vector.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gate_share_arbiter_if.sv
// ----------------------------------------------------------------------------
// gate_share_arbiter_if
// Bundles the requester side (req, op_a, op_b, gnt, rsp_*), the shared gate
// cell side (gate_a, gate_b, gate_c) and the status flags (busy, err).
//   slave  : seen by the arbiter (inputs req/op_a/op_b/gate_c)
//   master : seen by the requesters / gate model driving the arbiter
// ----------------------------------------------------------------------------
interface gate_share_arbiter_if #(
    parameter int N_REQ = gate_arb_pkg::N_REQ_DEFAULT
);
    import gate_arb_pkg::*;

    localparam int ID_W = id_w(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] op_a;
    logic [N_REQ-1:0] op_b;
    logic [N_REQ-1:0] gnt;
    logic             gate_a;
    logic             gate_b;
    logic             gate_c;
    logic             rsp_valid;
    logic [ID_W-1:0]  rsp_id;
    logic             rsp_data;
    logic             busy;
    logic             err;

    modport slave (
        input  req, op_a, op_b, gate_c,
        output gnt, gate_a, gate_b, rsp_valid, rsp_id, rsp_data, busy, err
    );

    modport master (
        output req, op_a, op_b, gate_c,
        input  gnt, gate_a, gate_b, rsp_valid, rsp_id, rsp_data, busy, err
    );

endinterface

// File: rtl/gate_share_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req starting at ptr in ascending
// index order, wrapping N_REQ-1 -> 0, and returns the first active requester.
//   req        in  N_REQ  request levels
//   ptr        in  ID_W   search start index
//   winner_oh  out N_REQ  one-hot winner (0 when none)
//   winner_idx out ID_W   winner index (0 when none)
//   any        out 1      at least one request active
// ----------------------------------------------------------------------------
module rr_pick
    import gate_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [id_w(N_REQ)-1:0]  ptr,
    output logic [N_REQ-1:0]        winner_oh,
    output logic [id_w(N_REQ)-1:0]  winner_idx,
    output logic                    any
);
    localparam int ID_W = id_w(N_REQ);

    logic [ID_W-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves a value unassigned and no latch is inferred.
        winner_oh  = '0;
        winner_idx = '0;
        any        = 1'b0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // N_REQ is a power of two, so truncation to ID_W is the wrap.
            cand = ptr + ID_W'(i);
            if (!any && req[cand]) begin
                any             = 1'b1;
                winner_idx      = cand;
                winner_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_share_arbiter.sv
// ----------------------------------------------------------------------------
// gate_share_arbiter
// Time-shares one 2-input gate cell among N_REQ requesters. Each transaction
// takes three cycles: IDLE grants the round-robin winner and registers its
// operands onto gate_a/gate_b, DRIVE captures gate_c as the response, RESP
// drops the grant and advances the pointer past the winner.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  gate_share_arbiter_if.slave (requests, grants, gate cell, response,
//        busy, err)
// Optional build macro GATE_CHECK_EN: checks gate_c against gate_a & gate_b at
// the DRIVE edge and raises a sticky err on mismatch; otherwise err is 0.
// ----------------------------------------------------------------------------
module gate_share_arbiter
    import gate_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_share_arbiter_if.slave   bus
);
    localparam int ID_W = id_w(N_REQ);

    state_e           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win_id;
    logic [N_REQ-1:0] gnt_q;
    logic             gate_a_q;
    logic             gate_b_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic             rsp_data_q;

    logic [N_REQ-1:0] pick_oh;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (bus.req),
        .ptr        (ptr),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // NOTE: all state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            win_id      <= '0;
            gnt_q       <= '0;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gnt_q <= '0;
                    if (pick_any) begin
                        gnt_q    <= pick_oh;
                        win_id   <= pick_idx;
                        gate_a_q <= bus.op_a[pick_idx];
                        gate_b_q <= bus.op_b[pick_idx];
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    rsp_data_q  <= bus.gate_c;
                    rsp_id_q    <= win_id;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    gnt_q       <= '0;
                    ptr         <= win_id + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GATE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == DRIVE && bus.gate_c != (gate_a_q & gate_b_q)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gate_a    = gate_a_q;
    assign bus.gate_b    = gate_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state != IDLE);

endmodule
